e603_gnrl_banked_ram: RTL and testbench

Multi-bank single-port SRAM subsystem with per-bank automatic power management. It sits between a core-side memory port and `NB` instances of `e603_gnrl_tech_ram`. It word-interleaves accesses across banks, puts idle banks into light sleep and then deep sleep, and wakes them on demand behind a valid/ready handshake. It also supports a global shutdown request.

---
 rtl/e603_gnrl_banked_ram_pkg.sv | 19 +
 rtl/e603_gnrl_tech_ram.sv | 47 ++++
 rtl/e603_ram_bank_pwr.sv | 123 ++++++++++++
 rtl/e603_gnrl_banked_ram.sv | 121 ++++++++++++
 tb/tb_e603_gnrl_banked_ram.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/e603_gnrl_banked_ram_pkg.sv
// Shared types for the banked RAM subsystem: per-bank power state encoding
// and small elaboration-time helpers.
package e603_gnrl_banked_ram_pkg;

    localparam int BANK_ST_W = 3;

    typedef enum logic [BANK_ST_W-1:0] {
        BK_ACTIVE = 3'd0,
        BK_LS     = 3'd1,
        BK_DS     = 3'd2,
        BK_WAKE   = 3'd3,
        BK_SD     = 3'd4
    } bank_st_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/e603_gnrl_tech_ram.sv
// Behavioural single-port SRAM macro with byte-group write mask and
// light-sleep / deep-sleep / shutdown pins; accesses are ignored while asleep.
module e603_gnrl_tech_ram #(
    parameter int DP           = 512,
    parameter int DW           = 32,
    parameter int MW           = 4,
    parameter int AW           = 9,
    parameter int FORCE_X2ZERO = 0
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [MW-1:0] wem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    input  logic          sd,
    input  logic          ds,
    input  logic          ls
);

    localparam int GW = DW / MW;

    logic [DW-1:0] mem [DP];
    logic [DW-1:0] dout_q;
    logic          awake;

    assign awake = !(sd || ds || ls);

    // dout holds the last read word; writes leave it untouched
    always_ff @(posedge clk) begin
        if (cs && awake) begin
            if (we) begin
                for (int m = 0; m < MW; m++) begin
                    if (wem[m]) begin
                        mem[addr][m*GW +: GW] <= din[m*GW +: GW];
                    end
                end
            end else begin
                dout_q <= mem[addr];
            end
        end
    end

    assign dout = ((FORCE_X2ZERO != 0) && !awake) ? '0 : dout_q;

endmodule

// File: rtl/e603_ram_bank_pwr.sv
// Per-bank power manager: idle counter drives ACTIVE->LS->DS, a wake counter
// sequences the return to ACTIVE, and a global shutdown overrides everything.
module e603_ram_bank_pwr
    import e603_gnrl_banked_ram_pkg::*;
#(
    parameter int IDLE_LS = 16,
    parameter int IDLE_DS = 256,
    parameter int WAKE_LS = 1,
    parameter int WAKE_DS = 4,
    parameter int WAKE_SD = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     sd_req,
    input  logic     wake_req,
    input  logic     acc,
    output bank_st_e st,
    output logic     ls,
    output logic     ds,
    output logic     sd
);

    localparam int IMAX = max_int(IDLE_LS, IDLE_DS);
    localparam int ICW  = $clog2(IMAX + 1);
    localparam int WMAX = max_int(WAKE_SD, max_int(WAKE_LS, WAKE_DS));
    localparam int WCW  = $clog2(WMAX + 1);

    localparam logic [ICW-1:0] IMAX_V    = ICW'(IMAX);
    localparam logic [ICW-1:0] IDLE_LS_V = ICW'(IDLE_LS);
    localparam logic [ICW-1:0] IDLE_DS_V = ICW'(IDLE_DS);

    bank_st_e       st_q, st_d;
    logic [ICW-1:0] icnt_q, icnt_d, icnt_inc;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           ls_q, ls_d, ds_q, ds_d, sd_q, sd_d;

    assign icnt_inc = (icnt_q == IMAX_V) ? icnt_q : icnt_q + ICW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= BK_ACTIVE;
            icnt_q <= '0;
            wcnt_q <= '0;
            ls_q   <= 1'b0;
            ds_q   <= 1'b0;
            sd_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            icnt_q <= icnt_d;
            wcnt_q <= wcnt_d;
            ls_q   <= ls_d;
            ds_q   <= ds_d;
            sd_q   <= sd_d;
        end
    end

    // Thresholds compare against the incremented count so a bank enters LS
    // on the edge its idle count becomes IDLE_LS; a same-cycle access wins.
    always_comb begin
        st_d   = st_q;
        icnt_d = icnt_inc;
        wcnt_d = wcnt_q;
        ls_d   = ls_q;
        ds_d   = ds_q;
        sd_d   = sd_q;
        if (sd_req) begin
            st_d = BK_SD;
            sd_d = 1'b1;
            ls_d = 1'b0;
            ds_d = 1'b0;
        end else begin
            case (st_q)
                BK_ACTIVE: begin
                    if (acc) begin
                        icnt_d = '0;
                    end else if (icnt_inc == IDLE_LS_V) begin
                        st_d = BK_LS;
                        ls_d = 1'b1;
                    end
                end
                BK_LS: begin
                    if (wake_req) begin
                        st_d   = BK_WAKE;
                        wcnt_d = WCW'(WAKE_LS);
                    end else if ((IDLE_DS != 0) && (icnt_inc == IDLE_DS_V)) begin
                        st_d = BK_DS;
                        ds_d = 1'b1;
                        ls_d = 1'b0;
                    end
                end
                BK_DS: begin
                    if (wake_req) begin
                        st_d   = BK_WAKE;
                        wcnt_d = WCW'(WAKE_DS);
                    end
                end
                BK_SD: begin
                    st_d   = BK_WAKE;
                    wcnt_d = WCW'(WAKE_SD);
                end
                BK_WAKE: begin
                    // sleep pins stay asserted until the macro has recovered
                    wcnt_d = wcnt_q - WCW'(1);
                    if (wcnt_q <= WCW'(1)) begin
                        st_d   = BK_ACTIVE;
                        icnt_d = '0;
                        wcnt_d = '0;
                        ls_d   = 1'b0;
                        ds_d   = 1'b0;
                        sd_d   = 1'b0;
                    end
                end
                default: st_d = BK_ACTIVE;
            endcase
        end
    end

    assign st = st_q;
    assign ls = ls_q;
    assign ds = ds_q;
    assign sd = sd_q;

endmodule

// File: rtl/e603_gnrl_banked_ram.sv
// Word-interleaved multi-bank SRAM with per-bank power management behind a
// valid/ready request port and a one-cycle read response.
module e603_gnrl_banked_ram
    import e603_gnrl_banked_ram_pkg::*;
#(
    parameter int NB           = 2,
    parameter int DP           = 1024,
    parameter int DW           = 32,
    parameter int MW           = 4,
    parameter int AW           = 32,
    parameter int IDLE_LS      = 16,
    parameter int IDLE_DS      = 256,
    parameter int WAKE_LS      = 1,
    parameter int WAKE_DS      = 4,
    parameter int WAKE_SD      = 8,
    parameter int FORCE_X2ZERO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sd_req,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [MW-1:0]   req_wem,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [3*NB-1:0] bank_st
);

    localparam int BW  = $clog2(NB);
    localparam int BDP = DP / NB;
    localparam int RW  = $clog2(BDP);

    logic [BW-1:0] bank_sel;
    logic [RW-1:0] row_sel;
    logic          acc;
    bank_st_e      st        [NB];
    logic [DW-1:0] bank_dout [NB];
    logic          rsp_vld_p1;
    logic [BW-1:0] rsp_bank_p1;

    assign bank_sel = req_addr[BW-1:0];
    assign row_sel  = req_addr[BW+RW-1:BW];

    generate
        if (AW > BW + RW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[AW-1:BW+RW];
        end
    endgenerate

    assign req_ready = !sd_req && (st[bank_sel] == BK_ACTIVE);
    assign acc       = req_valid && req_ready;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_bank
            logic bank_hit;
            logic ls, ds, sd;

            assign bank_hit = (bank_sel == BW'(i));

            e603_ram_bank_pwr #(
                .IDLE_LS (IDLE_LS),
                .IDLE_DS (IDLE_DS),
                .WAKE_LS (WAKE_LS),
                .WAKE_DS (WAKE_DS),
                .WAKE_SD (WAKE_SD)
            ) u_pwr (
                .clk      (clk),
                .rst_n    (rst_n),
                .sd_req   (sd_req),
                .wake_req (req_valid && bank_hit),
                .acc      (acc && bank_hit),
                .st       (st[i]),
                .ls       (ls),
                .ds       (ds),
                .sd       (sd)
            );

            e603_gnrl_tech_ram #(
                .DP           (BDP),
                .DW           (DW),
                .MW           (MW),
                .AW           (RW),
                .FORCE_X2ZERO (FORCE_X2ZERO)
            ) u_ram (
                .clk  (clk),
                .cs   (acc && bank_hit),
                .we   (req_we),
                .wem  (req_wem),
                .addr (row_sel),
                .din  (req_wdata),
                .dout (bank_dout[i]),
                .sd   (sd),
                .ds   (ds),
                .ls   (ls)
            );

            assign bank_st[3*i +: 3] = st[i];
        end
    endgenerate

    // p1: response stage, remembers which bank's dout carries the read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_p1  <= 1'b0;
            rsp_bank_p1 <= '0;
        end else begin
            rsp_vld_p1 <= acc && !req_we;
            if (acc && !req_we) begin
                rsp_bank_p1 <= bank_sel;
            end
        end
    end

    assign rsp_valid = rsp_vld_p1;
    assign rsp_rdata = rsp_vld_p1 ? bank_dout[rsp_bank_p1] : '0;

endmodule

// File: tb/tb_e603_gnrl_banked_ram.sv
// Directed bench for the banked RAM: idle-time based power model plus
// hand-computed expectations for wake latencies, data and shutdown.
module tb_e603_gnrl_banked_ram;

    localparam int NB = 2, DP = 1024, DW = 32, MW = 4, AW = 32;
    localparam int IDLE_LS = 4, IDLE_DS = 16, WAKE_LS = 1, WAKE_DS = 4, WAKE_SD = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sd_req = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wem = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [3*NB-1:0] bank_st;

    always #5 clk = ~clk;

    e603_gnrl_banked_ram #(
        .NB(NB), .DP(DP), .DW(DW), .MW(MW), .AW(AW),
        .IDLE_LS(IDLE_LS), .IDLE_DS(IDLE_DS),
        .WAKE_LS(WAKE_LS), .WAKE_DS(WAKE_DS), .WAKE_SD(WAKE_SD),
        .FORCE_X2ZERO(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sd_req(sd_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wem(req_wem),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bank_st(bank_st)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: a bank's state follows from how long it has been idle, whether
    // it is shut down, and the cycle at which a pending wake completes.
    int  m_idle [NB];
    int  m_wake_end [NB];
    bit  m_shut [NB];
    int  m_cyc = 0;
    logic [31:0] m_mem [int];
    bit  m_rv = 1'b0;
    bit  m_rk = 1'b0;
    logic [31:0] m_rd = '0;

    function automatic int state_of(input int b);
        if (m_shut[b]) return 4;
        if (m_cyc < m_wake_end[b]) return 3;
        if (m_idle[b] >= IDLE_DS) return 2;
        if (m_idle[b] >= IDLE_LS) return 1;
        return 0;
    endfunction

    task automatic model_step();
        int bk, key;
        int cur [NB];
        bit acc;
        logic [31:0] word;
        bk  = int'(req_addr[0]);
        key = int'(req_addr[9:0]);
        for (int b = 0; b < NB; b++) cur[b] = state_of(b);
        acc  = req_valid && !sd_req && (cur[bk] == 0);
        m_rv = acc && !req_we;
        m_rk = 1'b0;
        m_rd = '0;
        if (m_rv && m_mem.exists(key)) begin
            m_rk = 1'b1;
            m_rd = m_mem[key];
        end
        if (acc && req_we) begin
            if (m_mem.exists(key) || req_wem == 4'hF) begin
                word = m_mem.exists(key) ? m_mem[key] : 32'h0;
                for (int m = 0; m < MW; m++)
                    if (req_wem[m]) word[m*8 +: 8] = req_wdata[m*8 +: 8];
                m_mem[key] = word;
            end
        end
        m_cyc++;
        for (int b = 0; b < NB; b++) begin
            if (sd_req) begin
                m_shut[b] = 1'b1;
                m_idle[b] = 0;
            end else if (cur[b] == 4) begin
                m_shut[b]     = 1'b0;
                m_wake_end[b] = m_cyc + WAKE_SD;
                m_idle[b]     = 0;
            end else if (cur[b] == 3) begin
                m_idle[b] = 0;
            end else if (cur[b] == 0 && acc && bk == b) begin
                m_idle[b] = 0;
            end else if (cur[b] != 0 && req_valid && bk == b) begin
                m_wake_end[b] = m_cyc + ((cur[b] == 1) ? WAKE_LS : WAKE_DS);
                m_idle[b]     = 0;
            end else begin
                m_idle[b]++;
            end
        end
        if (sd_req) m_mem.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int b = 0; b < NB; b++) begin
                    m_idle[b] = 0;
                    m_wake_end[b] = 0;
                    m_shut[b] = 1'b0;
                end
                m_rv = 1'b0;
                m_rk = 1'b0;
                m_rd = '0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("bank_st", 32'(bank_st), 32'({3'(state_of(1)), 3'(state_of(0))}));
                check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
                if (!m_rv) check("rsp_rdata_idle", rsp_rdata, 32'h0);
                else if (m_rk) check("rsp_rdata", rsp_rdata, m_rd);
                check("req_ready", 32'(req_ready),
                      32'(!sd_req && (state_of(int'(req_addr[0])) == 0)));
            end
        end
    end

    // Called just after a falling edge; returns on the falling edge after
    // acceptance, which is the response cycle for a read.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int lat);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wem   = m;
        lat = 0;
        #1;
        while (!req_ready && lat < 50) begin
            @(negedge clk);
            lat++;
            #1;
        end
        if (!req_ready) begin
            n_tot++;
            $display("FAIL access_timeout: addr 0x%08h not accepted after %0d cycles", a, lat);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("reset_bank_st", 32'(bank_st), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'h1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // basic write/read with ready held high
        access(1'b1, 32'd0, 32'hCAFEF00D, 4'hF, lat);
        check("t1_wr0_lat", lat, 0);
        access(1'b1, 32'd1, 32'h0BADBEEF, 4'hF, lat);
        access(1'b1, 32'd3, 32'hA5A51234, 4'hF, lat);
        check("t1_wr3_lat", lat, 0);
        access(1'b0, 32'd3, 32'h0, 4'hF, lat);
        check("t1_rd3_lat", lat, 0);
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rdata", rsp_rdata, 32'hA5A51234);

        // bank 1 light sleep after 4 idle cycles, then wake from LS
        repeat (3) @(negedge clk);
        check("t3_b1_active", 32'(bank_st[5:3]), 32'd0);
        @(negedge clk);
        check("t3_b1_ls", 32'(bank_st[5:3]), 32'd1);
        access(1'b0, 32'd1, 32'h0, 4'hF, lat);
        check("t3_wake_lat", lat, 2);
        check("t3_rdata", rsp_rdata, 32'h0BADBEEF);

        // masked write merge
        access(1'b1, 32'd6, 32'h11111111, 4'hF, lat);
        access(1'b1, 32'd6, 32'h0000FF00, 4'b0010, lat);
        access(1'b0, 32'd6, 32'h0, 4'hF, lat);
        check("t2_rdata", rsp_rdata, 32'h1111FF11);

        // bank 0 deep sleep after 16 idle cycles, then wake from DS
        repeat (15) @(negedge clk);
        check("t4_b0_ls", 32'(bank_st[2:0]), 32'd1);
        @(negedge clk);
        check("t4_b0_ds", 32'(bank_st[2:0]), 32'd2);
        access(1'b0, 32'd0, 32'h0, 4'hF, lat);
        check("t4_wake_lat", lat, 5);
        check("t4_rdata", rsp_rdata, 32'hCAFEF00D);

        // shutdown pulse of 3 cycles
        sd_req = 1'b1;
        #1;
        check("t5_ready_sd", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("t5_all_sd", 32'(bank_st), 32'b100100);
        repeat (2) @(negedge clk);
        sd_req = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_still_wake", 32'(bank_st), 32'b011011);
        @(negedge clk);
        check("t5_active", 32'(bank_st), 32'h0);
        check("t5_ready", 32'(req_ready), 32'h1);

        // back-to-back reads interrupted by asynchronous reset
        for (int k = 0; k < 4; k++) access(1'b1, 32'(k), 32'h10000000 + 32'(k), 4'hF, lat);
        access(1'b0, 32'd0, 32'h0, 4'hF, lat);
        check("t6_rsp0", rsp_rdata, 32'h10000000);
        access(1'b0, 32'd1, 32'h0, 4'hF, lat);
        check("t6_rsp1", rsp_rdata, 32'h10000001);
        access(1'b0, 32'd2, 32'h0, 4'hF, lat);
        check("t6_rsp2_valid", 32'(rsp_valid), 32'h1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd3;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t6_rst_rsp_rdata", rsp_rdata, 32'h0);
        check("t6_rst_bank_st", 32'(bank_st), 32'h0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_dropped", 32'(rsp_valid), 32'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
